// File: rtl/jk_excite_ctrl.sv
// Sequencer that drives a bank of downstream JK flip-flops towards a requested state.
// It drives, verifies through q feedback, retries a bounded number of times, then flags an error.
module jk_excite_ctrl #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    input  logic             err_clr,
    output logic             busy,
    output logic [7:0]       xfer_cnt
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_tgt;
    logic [RW-1:0]    r_retry;
    logic [RW-1:0]    w_retry_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [7:0]       r_xfer_cnt;
    logic             w_take;
    logic             w_match;

    assign w_take   = (r_state == S_IDLE) && tgt_valid;
    assign w_match  = (q == r_tgt);
    assign done     = r_done;
    assign xfer_cnt = r_xfer_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_tgt      <= '0;
            r_retry    <= '0;
            r_done     <= 1'b0;
            r_xfer_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_retry <= w_retry_nxt;
            r_done  <= w_done_nxt;
            if (w_take) begin
                r_tgt <= tgt_data;
            end
            // Count moves together with the done pulse so both appear in the same cycle.
            if (w_done_nxt) begin
                r_xfer_cnt <= r_xfer_cnt + 8'd1;
            end
        end
    end

    // j/k are only non-zero in DRIVE, and only on bits that must move, so j=k=1 cannot occur.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_done_nxt  = 1'b0;
        tgt_ready   = 1'b0;
        busy        = 1'b1;
        err         = 1'b0;
        j           = '0;
        k           = '0;
        case (r_state)
            S_IDLE: begin
                tgt_ready = 1'b1;
                busy      = 1'b0;
                if (tgt_valid) begin
                    w_state_nxt = S_DRIVE;
                    w_retry_nxt = '0;
                end
            end
            S_DRIVE: begin
                j           = ~q & r_tgt;
                k           = q & ~r_tgt;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (w_match) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_retry < RETRY_LIM) begin
                    w_retry_nxt = r_retry + RW'(1);
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                err = 1'b1;
                if (err_clr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Bench for jk_excite_ctrl: a JK bank model closes the q loop, and a transaction-level
// schedule model predicts every output each cycle; directed literals pin key cycles.
module tb_jk_excite_ctrl;

    localparam int MAXR    = 2;
    localparam int M_NORM  = 0;
    localparam int M_STUCK = 1;
    localparam int M_SKIP1 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] tgt_data;
    logic [3:0] j;
    logic [3:0] k;
    logic       done;
    logic       err;
    logic       err_clr;
    logic       busy;
    logic [7:0] xfer_cnt;

    logic [3:0] q_bank = 4'h0;
    logic       skipped = 1'b0;
    int         bank_mode;
    logic       q_load_en;
    logic [3:0] q_load_val;

    byte        m_code;
    byte        m_sched[$];
    logic [3:0] m_tgt;
    logic [7:0] m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    jk_excite_ctrl #(.WIDTH(4), .MAX_RETRY(MAXR)) dut (
        .clk       (clk),
        .reset     (reset),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .q         (q_bank),
        .j         (j),
        .k         (k),
        .done      (done),
        .err       (err),
        .err_clr   (err_clr),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Downstream JK bank: normal response, stuck, or ignoring its first non-hold drive.
    always @(posedge clk) begin
        logic [3:0] nq;
        nq = q_bank;
        for (int i = 0; i < 4; i++) begin
            if (j[i] && k[i])  nq[i] = ~q_bank[i];
            else if (j[i])     nq[i] = 1'b1;
            else if (k[i])     nq[i] = 1'b0;
        end
        if (q_load_en)                                       q_bank <= q_load_val;
        else if (bank_mode == M_STUCK)                       q_bank <= q_bank;
        else if (bank_mode == M_SKIP1 && !skipped && (j | k) != 4'h0) skipped <= 1'b1;
        else                                                 q_bank <= nq;
        if (bank_mode != M_SKIP1) skipped <= 1'b0;
    end

    // Number of drive attempts the bank needs before q equals the target.
    function automatic int attempts(input logic [3:0] t, input logic [3:0] qv);
        if (t == qv) return 1;
        if (bank_mode == M_STUCK) return 1000;
        if (bank_mode == M_SKIP1 && !skipped) return 2;
        return 1;
    endfunction

    // Schedule model: I idle, D drive, C check, O done cycle, E error.
    always @(posedge clk or negedge reset) begin
        int a;
        int n;
        if (!reset) begin
            m_code = "I";
            m_sched.delete();
            m_cnt  = 8'd0;
            m_tgt  = 4'h0;
        end else begin
            if (m_code == "E") begin
                if (err_clr) m_code = "I";
            end else if (tgt_valid && (m_code == "I" || m_code == "O")) begin
                m_tgt = tgt_data;
                a = attempts(tgt_data, q_bank);
                n = (a <= MAXR + 1) ? a : MAXR + 1;
                m_sched.delete();
                for (int i = 0; i < n; i++) begin
                    m_sched.push_back("D");
                    m_sched.push_back("C");
                end
                m_sched.push_back((a <= MAXR + 1) ? "O" : "E");
                m_code = m_sched.pop_front();
            end else if (m_sched.size() > 0) begin
                m_code = m_sched.pop_front();
            end else begin
                m_code = "I";
            end
            if (m_code == "O") m_cnt = m_cnt + 8'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_cycle();
        logic idle_like;
        logic [3:0] ej;
        logic [3:0] ek;
        idle_like = (m_code == "I" || m_code == "O");
        ej = (m_code == "D") ? (~q_bank & m_tgt) : 4'h0;
        ek = (m_code == "D") ? (q_bank & ~m_tgt) : 4'h0;
        chk("tgt_ready", 32'(tgt_ready), 32'(idle_like));
        chk("busy",      32'(busy),      32'(!idle_like));
        chk("done",      32'(done),      32'(m_code == "O"));
        chk("err",       32'(err),       32'(m_code == "E"));
        chk("j",         32'(j),         32'(ej));
        chk("k",         32'(k),         32'(ek));
        chk("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
        chk("no_toggle", 32'(j & k),     32'h0);
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_q(input logic [3:0] v);
        q_load_en  = 1'b1;
        q_load_val = v;
        tick();
        q_load_en  = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        chk("rst_cnt",   32'(xfer_cnt),  32'h0);
        chk("rst_ready", 32'(tgt_ready), 32'h1);
        chk("rst_busy",  32'(busy),      32'h0);
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        tgt_valid  = 1'b0;
        tgt_data   = 4'h0;
        err_clr    = 1'b0;
        bank_mode  = M_NORM;
        q_load_en  = 1'b0;
        q_load_val = 4'h0;
        @(posedge clk);
        #1;
        // Transfers offered during reset must not be taken.
        tgt_valid = 1'b1;
        tgt_data  = 4'h9;
        apply_reset();
        tgt_valid = 1'b0;
        tick();

        // Basic transfer: q=0011 -> 0101.
        load_q(4'b0011);
        tgt_valid = 1'b1;
        tgt_data  = 4'b0101;
        tick();
        tgt_valid = 1'b0;
        chk("basic_j",  32'(j), 32'h4);
        chk("basic_k",  32'(k), 32'h2);
        chk("basic_c1_done", 32'(done), 32'h0);
        tick();
        chk("basic_c2_done", 32'(done), 32'h0);
        tick();
        chk("basic_c3_done", 32'(done), 32'h1);
        chk("basic_cnt",     32'(xfer_cnt), 32'h1);
        tick();

        // Back-to-back with tgt_valid held.
        apply_reset();
        tgt_valid = 1'b1;
        tgt_data  = 4'hA;
        tick();
        tgt_data  = 4'h5;
        tick();
        tick();
        chk("b2b_done1", 32'(done), 32'h1);
        tick();
        chk("b2b_busy2", 32'(busy), 32'h1);
        chk("b2b_j2",    32'(j),    32'h5);
        chk("b2b_k2",    32'(k),    32'hA);
        tgt_valid = 1'b0;
        tick();
        tick();
        chk("b2b_done2", 32'(done),     32'h1);
        chk("b2b_cnt",   32'(xfer_cnt), 32'h2);
        tick();

        // err_clr outside ERR has no effect.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_idle_busy", 32'(busy),     32'h0);
        chk("clr_idle_cnt",  32'(xfer_cnt), 32'h2);

        // Retry exhaustion: q stuck at 0, target F.
        apply_reset();
        load_q(4'h0);
        bank_mode = M_STUCK;
        tgt_valid = 1'b1;
        tgt_data  = 4'hF;
        tick();
        tgt_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("retry_drive_j", 32'(j), 32'hF);
            tick();
            chk("retry_check_j", 32'(j), 32'h0);
            tick();
        end
        chk("err_set",   32'(err),       32'h1);
        chk("err_ready", 32'(tgt_ready), 32'h0);
        tgt_valid = 1'b1;
        tgt_data  = 4'h3;
        tick();
        chk("err_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr   = 1'b0;
        tgt_valid = 1'b0;
        chk("err_clr_err",   32'(err),       32'h0);
        chk("err_clr_ready", 32'(tgt_ready), 32'h1);
        tick();
        bank_mode = M_NORM;

        // Bank ignores the first drive only: one retry, done in cycle 5.
        load_q(4'b0011);
        bank_mode = M_SKIP1;
        tgt_valid = 1'b1;
        tgt_data  = 4'b1100;
        tick();
        tgt_valid = 1'b0;
        tick();
        tick();
        chk("skip_redrive_j", 32'(j), 32'hC);
        tick();
        tick();
        chk("skip_done", 32'(done), 32'h1);
        chk("skip_err",  32'(err),  32'h0);
        tick();
        bank_mode = M_NORM;

        // Target equal to q still runs DRIVE/CHECK then done.
        tgt_valid = 1'b1;
        tgt_data  = 4'b1100;
        tick();
        tgt_valid = 1'b0;
        chk("same_busy", 32'(busy), 32'h1);
        chk("same_jk",   32'(j | k), 32'h0);
        tick();
        tick();
        chk("same_done", 32'(done), 32'h1);
        tick();

        // Asynchronous reset in the middle of DRIVE.
        apply_reset();
        load_q(4'b1010);
        tgt_valid = 1'b1;
        tgt_data  = 4'hF;
        tick();
        tgt_valid = 1'b0;
        chk("arst_pre_j", 32'(j), 32'h5);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_j",    32'(j),        32'h0);
        chk("arst_k",    32'(k),        32'h0);
        chk("arst_busy", 32'(busy),     32'h0);
        chk("arst_cnt",  32'(xfer_cnt), 32'h0);
        tick();
        tick();
        chk("arst_no_done", 32'(done), 32'h0);
        reset = 1'b1;
        tick();

        // 256 completed targets wrap the counter back to 0.
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            tgt_valid = 1'b1;
            tgt_data  = 4'(i * 7 + 3);
            tick();
            tgt_valid = 1'b0;
            tick();
            tick();
            if (i == 254) chk("wrap_255", 32'(xfer_cnt), 32'hFF);
        end
        chk("wrap_done", 32'(done),     32'h1);
        chk("wrap_0",    32'(xfer_cnt), 32'h0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_excite_ctrl.md
JK_EXCITE_CTRL -- requirements
Module: jk_excite_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, number of downstream JK flip-flops driven.
REQ-002 Parameter: MAX_RETRY, default 2, drive attempts allowed after the first before an error is declared.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; 0 resets immediately, released synchronously to clk.
REQ-005 Port: tgt_valid  input  1  target state offered.
REQ-006 Port: tgt_ready  output  1  block can accept a target.
REQ-007 Port: tgt_data  input  WIDTH  requested next state of the JK bank.
REQ-008 Port: q  input  WIDTH  feedback, current outputs of the downstream JK bank.
REQ-009 Port: j  output  WIDTH  J inputs to the JK bank.
REQ-010 Port: k  output  WIDTH  K inputs to the JK bank.
REQ-011 Port: done  output  1  one-cycle pulse, target reached.
REQ-012 Port: err  output  1  sticky, target not reached within retry budget.
REQ-013 Port: err_clr  input  1  clears err and returns to IDLE.
REQ-014 Port: busy  output  1  high in any state other than IDLE.
REQ-015 Port: xfer_cnt  output  8  count of completed targets, wraps 255->0.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, DRIVE, CHECK, ERR.
REQ-017 IDLE: tgt_ready=1; a transfer occurs on a rising edge with tgt_valid=1 and tgt_ready=1; tgt_data is then latched into tgt_reg, retry count is cleared, and the next state is DRIVE.
REQ-018 tgt_ready SHALL be 0 in DRIVE, CHECK and ERR; tgt_valid there SHALL be ignored and tgt_data not sampled.
REQ-019 DRIVE: lasts exactly one cycle; per bit i, j[i] = ~q[i] & tgt_reg[i] and k[i] = q[i] & ~tgt_reg[i] (combinational from q); next state is CHECK.
REQ-020 Outside DRIVE, j and k SHALL both be all-zero (downstream hold), so the toggle code j=k=1 is never emitted.
REQ-021 CHECK: lasts one cycle; if q == tgt_reg, the next state is IDLE and done pulses high for the first IDLE cycle.
REQ-022 CHECK with q != tgt_reg: if retry count < MAX_RETRY, increment it and return to DRIVE; otherwise go to ERR.
REQ-023 Nominal latency: transfer edge -> DRIVE (cycle 1) -> CHECK (cycle 2) -> done in cycle 3; a new transfer is accepted in the done cycle (3-cycle throughput).
REQ-024 xfer_cnt SHALL increment by 1 on each done pulse, modulo 256.
REQ-025 ERR: err=1, busy=1, j=k=0; leaves only on err_clr=1 at a rising edge, going to IDLE with err=0 the next cycle.
REQ-026 err_clr outside ERR SHALL have no effect.
REQ-027 A target equal to the current q SHALL still pass DRIVE (j=k=0) and CHECK, then pulse done.

Reset
REQ-028 While reset=0: state=IDLE, tgt_reg=0, retry count=0, j=0, k=0, done=0, err=0, busy=0, xfer_cnt=0, tgt_ready=1; transfers are not taken.
REQ-029 Reset asserted in DRIVE or CHECK SHALL force j=k=0 immediately (asynchronously) and abandon the target without a done pulse.

Verification
REQ-030 Reset: reset=0 mid-DRIVE with j=4'b0101 -> j=k=0 and busy=0 without a clock edge; xfer_cnt=0.
REQ-031 Basic: q=4'b0011, transfer tgt_data=4'b0101; JK bank model responds -> DRIVE cycle j=4'b0100, k=4'b0010; done in cycle 3; xfer_cnt=1.
REQ-032 Back-to-back: tgt_valid held with 4'hA then 4'h5 -> second transfer accepted in first done cycle; done pulses 3 cycles apart; xfer_cnt=2.
REQ-033 Retry/error: q stuck at 4'h0, target 4'hF, MAX_RETRY=2 -> three DRIVE cycles with j=4'hF, then ERR with err=1, tgt_ready=0; err_clr -> IDLE, err=0.
REQ-034 Stuck for one cycle: model ignores first DRIVE only -> one retry, done after 5 cycles, err stays 0.
REQ-035 Wrap: 256 completed targets from xfer_cnt=0 -> xfer_cnt=0; j and k never both 1 on any bit in any cycle.
